// File: rtl/uart_stream_thread_pkg.sv
// uart_stream_thread_pkg
//   Shared definitions for the UART stream thread: instruction opcodes,
//   instruction field positions, controller state encoding and the
//   snapshot-capture sub-phase used while waiting for the UART lock.
package uart_stream_thread_pkg;

    typedef enum logic [1:0] {
        OP_TERM  = 2'b00,
        OP_WRITE = 2'b01,
        OP_JUMP  = 2'b10,
        OP_WAIT  = 2'b11
    } opcode_t;

    // Instruction field positions (lsb, width)
    localparam int unsigned F_ADDR_LSB = 2;
    localparam int unsigned F_ADDR_W   = 8;
    localparam int unsigned F_HDR_LSB  = 10;
    localparam int unsigned F_HDR_W    = 8;
    localparam int unsigned F_NW_LSB   = 18;
    localparam int unsigned F_NW_W     = 8;
    localparam int unsigned F_TGT_LSB  = 2;
    localparam int unsigned F_TGT_W    = 8;
    localparam int unsigned F_CNT_LSB  = 2;
    localparam int unsigned F_CNT_W    = 24;

    // Byte count is sent as this many little-endian bytes before the header
    localparam int unsigned COUNT_BYTES = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOCK,
        S_COUNT,
        S_HEADER,
        S_DATA,
        S_RELEASE,
        S_WAIT
    } state_t;

    typedef enum logic [1:0] {
        SNAP_ENTRY,
        SNAP_LOAD,
        SNAP_TAKEN
    } snap_t;

endpackage

// File: rtl/uart_stream_thread_serializer.sv
// uart_byte_serializer
//   Holds the block snapshot and emits the byte stream
//   [bytecount LE x4][header][snapshot bytes] under valid/ready.
//   i_start      : present byte 0 next cycle
//   i_abort      : drop tx_valid next cycle
//   i_snap_load  : capture i_snap_data into the snapshot
//   o_accept     : handshake this cycle; o_idx is the byte being offered
//   o_last       : o_idx is the final byte of the stream
module uart_byte_serializer
    import uart_stream_thread_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned BLOCK_WORDS = 16
)(
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          i_abort,
    input  logic                          i_start,
    input  logic                          i_snap_load,
    input  logic [BLOCK_WORDS*DATA_W-1:0] i_snap_data,
    input  logic [7:0]                    i_nwords,
    input  logic [7:0]                    i_header,
    input  logic                          i_tx_ready,
    output logic [7:0]                    o_tx_data,
    output logic                          o_tx_valid,
    output logic                          o_accept,
    output logic                          o_last,
    output logic [15:0]                   o_idx
);

    localparam int unsigned BPW    = DATA_W / 8;
    localparam int unsigned SNAP_W = BLOCK_WORDS * DATA_W;

    logic [SNAP_W-1:0] r_snap;
    logic [7:0]        r_data;
    logic              r_valid;
    logic [15:0]       r_idx;

    logic [31:0] w_count;
    logic [15:0] w_total;
    logic [15:0] w_sel;
    logic [15:0] w_didx;
    logic [7:0]  w_byte;

    assign w_count = 32'd1 + 32'(BPW) * 32'(i_nwords);
    assign w_total = 16'(COUNT_BYTES + 1) + 16'(BPW) * 16'(i_nwords);

    // Byte for the index that will be presented next; the snapshot is laid
    // out little-endian per word, so the data stream is just its bytes in order.
    always_comb begin
        w_sel  = i_start ? '0 : r_idx + 16'd1;
        w_didx = w_sel - 16'(COUNT_BYTES + 1);
        w_byte = 8'(r_snap >> {w_didx, 3'b000});
        if (w_sel < 16'(COUNT_BYTES))
            w_byte = 8'(w_count >> {w_sel[1:0], 3'b000});
        else if (w_sel == 16'(COUNT_BYTES))
            w_byte = i_header;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_snap  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
        end else begin
            if (i_snap_load)
                r_snap <= i_snap_data;
            if (i_abort) begin
                r_valid <= 1'b0;
            end else if (i_start) begin
                r_valid <= 1'b1;
                r_data  <= w_byte;
                r_idx   <= '0;
            end else if (o_accept) begin
                if (o_last) begin
                    r_valid <= 1'b0;
                end else begin
                    r_idx  <= r_idx + 16'd1;
                    r_data <= w_byte;
                end
            end
        end
    end

    assign o_accept   = r_valid & i_tx_ready;
    assign o_last     = (r_idx == w_total - 16'd1);
    assign o_idx      = r_idx;
    assign o_tx_data  = r_data;
    assign o_tx_valid = r_valid;

endmodule

// File: rtl/uart_stream_thread.sv
// uart_stream_thread
//   Runs a tiny instruction program from imem that streams bmem blocks to a
//   shared UART: TERMINATE / WRITE / JUMP / WAIT.
//   running   : enable, rising edge starts at pc=0, low aborts
//   idle      : controller is idle
//   imem_*    : instruction fetch (combinational read at pc)
//   bmem_*    : block base address out, flat block back one cycle later
//   lock_*    : UART ownership request/grant
//   tx_*      : byte stream to the UART (valid/ready)
//   err       : sticky fault (bad nwords, lock lost)
module uart_stream_thread
    import uart_stream_thread_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned BLOCK_WORDS = 16,
    parameter int unsigned ADDR_SHIFT  = 8,
    parameter int unsigned PC_W        = 32
)(
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          running,
    output logic                          idle,
    output logic [PC_W-1:0]               imem_addr,
    input  logic [31:0]                   imem_data,
    output logic [PC_W-1:0]               bmem_addr,
    input  logic [BLOCK_WORDS*DATA_W-1:0] bmem_data,
    output logic                          lock_req,
    input  logic                          lock_grant,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          err
);

    localparam logic [7:0] BW8 = 8'(BLOCK_WORDS);

    state_t          r_state, w_state_next;
    snap_t           r_snap, w_snap_next;
    logic [PC_W-1:0] r_pc, w_pc_next;
    logic [PC_W-1:0] r_bmem_addr, w_bmem_addr_next;
    logic            r_lock_req, w_lock_req_next;
    logic            r_err, w_err_next;
    logic            r_running_q;
    logic [23:0]     r_cnt, w_cnt_next;
    logic [7:0]      r_hdr, w_hdr_next;
    logic [7:0]      r_nwords, w_nwords_next;

    logic            w_start, w_abort, w_snap_load;
    logic            w_accept, w_last;
    logic [15:0]     w_idx;

    opcode_t         w_op;
    logic [7:0]      w_f_addr, w_f_hdr, w_f_nw, w_f_tgt;
    logic [23:0]     w_f_cnt;
    logic            w_unused;

    assign w_op     = opcode_t'(imem_data[1:0]);
    assign w_f_addr = imem_data[F_ADDR_LSB +: F_ADDR_W];
    assign w_f_hdr  = imem_data[F_HDR_LSB  +: F_HDR_W];
    assign w_f_nw   = imem_data[F_NW_LSB   +: F_NW_W];
    assign w_f_tgt  = imem_data[F_TGT_LSB  +: F_TGT_W];
    assign w_f_cnt  = imem_data[F_CNT_LSB  +: F_CNT_W];
    assign w_unused = &{1'b0, imem_data[31:26]};

    always_comb begin
        w_state_next     = r_state;
        w_snap_next      = r_snap;
        w_pc_next        = r_pc;
        w_bmem_addr_next = r_bmem_addr;
        w_lock_req_next  = r_lock_req;
        w_err_next       = r_err;
        w_cnt_next       = r_cnt;
        w_hdr_next       = r_hdr;
        w_nwords_next    = r_nwords;
        w_start          = 1'b0;
        w_abort          = 1'b0;
        w_snap_load      = 1'b0;

        if (r_state != S_IDLE && !running) begin
            w_state_next    = S_IDLE;
            w_lock_req_next = 1'b0;
            w_abort         = 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (running && !r_running_q) begin
                        w_pc_next    = '0;
                        w_err_next   = 1'b0;
                        w_state_next = S_FETCH;
                    end
                end
                S_FETCH: begin
                    unique case (w_op)
                        OP_TERM:  w_state_next = S_IDLE;
                        OP_JUMP:  w_pc_next = PC_W'({w_f_tgt, 2'b00});
                        OP_WAIT: begin
                            if (w_f_cnt == '0) begin
                                w_pc_next = r_pc + PC_W'(4);
                            end else begin
                                w_cnt_next   = w_f_cnt;
                                w_state_next = S_WAIT;
                            end
                        end
                        OP_WRITE: begin
                            if (w_f_nw > BW8) begin
                                w_err_next   = 1'b1;
                                w_state_next = S_IDLE;
                            end else begin
                                w_hdr_next       = w_f_hdr;
                                w_nwords_next    = (w_f_nw == 8'd0) ? BW8 : w_f_nw;
                                w_bmem_addr_next = PC_W'(w_f_addr) << ADDR_SHIFT;
                                w_lock_req_next  = 1'b1;
                                w_snap_next      = SNAP_ENTRY;
                                w_state_next     = S_LOCK;
                            end
                        end
                    endcase
                end
                S_LOCK: begin
                    // bmem_addr changed on entry; bmem_data is valid one
                    // cycle later, so capture in the second LOCK cycle.
                    w_snap_load = (r_snap == SNAP_LOAD);
                    if (r_snap == SNAP_ENTRY)
                        w_snap_next = SNAP_LOAD;
                    else if (r_snap == SNAP_LOAD)
                        w_snap_next = SNAP_TAKEN;
                    if (lock_grant && r_snap == SNAP_TAKEN) begin
                        w_start      = 1'b1;
                        w_state_next = S_COUNT;
                    end
                end
                S_COUNT, S_HEADER, S_DATA: begin
                    if (!lock_grant) begin
                        w_err_next      = 1'b1;
                        w_lock_req_next = 1'b0;
                        w_abort         = 1'b1;
                        w_state_next    = S_IDLE;
                    end else if (w_accept) begin
                        if (r_state == S_COUNT && w_idx == 16'(COUNT_BYTES - 1))
                            w_state_next = S_HEADER;
                        else if (r_state == S_HEADER)
                            w_state_next = S_DATA;
                        else if (r_state == S_DATA && w_last) begin
                            w_lock_req_next = 1'b0;
                            w_state_next    = S_RELEASE;
                        end
                    end
                end
                S_RELEASE: begin
                    if (!lock_grant) begin
                        w_pc_next    = r_pc + PC_W'(4);
                        w_state_next = S_FETCH;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 24'd1) begin
                        w_pc_next    = r_pc + PC_W'(4);
                        w_state_next = S_FETCH;
                    end else begin
                        w_cnt_next = r_cnt - 24'd1;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_snap      <= SNAP_ENTRY;
            r_pc        <= '0;
            r_bmem_addr <= '0;
            r_lock_req  <= 1'b0;
            r_err       <= 1'b0;
            r_running_q <= 1'b0;
            r_cnt       <= '0;
            r_hdr       <= '0;
            r_nwords    <= '0;
        end else begin
            r_state     <= w_state_next;
            r_snap      <= w_snap_next;
            r_pc        <= w_pc_next;
            r_bmem_addr <= w_bmem_addr_next;
            r_lock_req  <= w_lock_req_next;
            r_err       <= w_err_next;
            r_running_q <= running;
            r_cnt       <= w_cnt_next;
            r_hdr       <= w_hdr_next;
            r_nwords    <= w_nwords_next;
        end
    end

    uart_byte_serializer #(
        .DATA_W      (DATA_W),
        .BLOCK_WORDS (BLOCK_WORDS)
    ) u_ser (
        .clock       (clock),
        .reset       (reset),
        .i_abort     (w_abort),
        .i_start     (w_start),
        .i_snap_load (w_snap_load),
        .i_snap_data (bmem_data),
        .i_nwords    (r_nwords),
        .i_header    (r_hdr),
        .i_tx_ready  (tx_ready),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .o_accept    (w_accept),
        .o_last      (w_last),
        .o_idx       (w_idx)
    );

    assign idle      = (r_state == S_IDLE);
    assign imem_addr = r_pc;
    assign bmem_addr = r_bmem_addr;
    assign lock_req  = r_lock_req;
    assign err       = r_err;

endmodule

// File: tb/tb_uart_stream_thread.sv
module tb_uart_stream_thread;

    logic         clock, reset, running, idle;
    logic [31:0]  imem_addr, imem_data, bmem_addr;
    logic [511:0] bmem_data;
    logic         lock_req, lock_grant;
    logic [7:0]   tx_data;
    logic         tx_valid, tx_ready, err;

    uart_stream_thread #(
        .DATA_W      (32),
        .BLOCK_WORDS (16),
        .ADDR_SHIFT  (8),
        .PC_W        (32)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .running    (running),
        .idle       (idle),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .bmem_addr  (bmem_addr),
        .bmem_data  (bmem_data),
        .lock_req   (lock_req),
        .lock_grant (lock_grant),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .err        (err)
    );

    // memories
    logic [31:0] im [0:255];
    logic [31:0] bm [0:4095];
    assign imem_data = im[imem_addr[9:2]];
    always @(posedge clock)
        for (int i = 0; i < 16; i++)
            bmem_data[i*32 +: 32] <= bm[{bmem_addr[15:8], 4'(i)}];

    // bench state
    int n_tests = 0, n_fail = 0;
    int ready_mode = 0;            // 0 always ready, 1 toggle, 2 random
    int grant_delay = 0, release_delay = 0;
    bit grant_kill = 0;
    logic [7:0] got_q[$], exp_q[$];
    int cyc = 0, hs_cnt, last_hs_cyc, fall_cyc, stall_cnt, stall_err;
    int early_tx, lockreq_cyc, rel_cyc, rel_err, at14;
    logic [31:0] rel_pc = 0;
    bit prev_stall, prev_lr;
    logic [7:0] prev_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_write(input int a, input int h, input int n);
        return {6'b0, 8'(n), 8'(h), 8'(a), 2'b01};
    endfunction
    function automatic logic [31:0] enc_jump(input int t);
        return {22'b0, 8'(t), 2'b10};
    endfunction
    function automatic logic [31:0] enc_wait(input int c);
        return {6'b0, 24'(c), 2'b11};
    endfunction

    // Reference stream: LE byte count, header, then each word LSB first.
    task automatic build_exp(input int a, input int h, input int n);
        int nw;
        logic [31:0] bc, w;
        nw = (n == 0) ? 16 : n;
        bc = 1 + 4 * nw;
        exp_q.delete();
        for (int b = 0; b < 4; b++) exp_q.push_back(8'((bc >> (8 * b)) & 32'hFF));
        exp_q.push_back(8'(h));
        for (int k = 0; k < nw; k++) begin
            w = bm[a * 16 + k];
            for (int b = 0; b < 4; b++) exp_q.push_back(8'((w >> (8 * b)) & 32'hFF));
        end
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
            chk($sformatf("%s_byte%0d", tag, k), got_q[k], exp_q[k]);
    endtask

    task automatic clr_prog();
        for (int i = 0; i < 256; i++) im[i] = 32'h0;
    endtask

    task automatic clr_stats();
        got_q.delete();
        hs_cnt = 0; last_hs_cyc = -1; fall_cyc = -1; stall_cnt = 0; stall_err = 0;
        early_tx = 0; lockreq_cyc = 0; rel_cyc = 0; rel_err = 0; at14 = 0;
        prev_stall = 0;
    endtask

    task automatic start_run();
        running = 0;
        repeat (2) @(posedge clock);
        #1;
        clr_stats();
        running = 1;
        @(posedge clock);
    endtask

    task automatic run_prog(input string tag, input int budget);
        bit ok;
        start_run();
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (idle) begin ok = 1; break; end
        end
        chk({tag, "_done"}, 32'(ok), 1);
    endtask

    task automatic wait_hs(input string tag, input int n);
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (hs_cnt >= n) begin ok = 1; break; end
        end
        chk({tag, "_reach"}, 32'(ok), 1);
    endtask

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    // tx_ready driver
    initial begin
        tx_ready = 1;
        forever begin
            @(posedge clock); #1;
            case (ready_mode)
                1:       tx_ready = ~tx_ready;
                2:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = 1;
            endcase
        end
    end

    // UART lock arbiter with programmable grant/release latency
    initial begin
        int gcnt, rcnt;
        gcnt = 0; rcnt = 0;
        lock_grant = 0;
        forever begin
            @(posedge clock); #1;
            if (grant_kill) lock_grant = 0;
            else if (lock_req === 1'b1 && !lock_grant) begin
                rcnt = 0;
                if (gcnt >= grant_delay) lock_grant = 1; else gcnt++;
            end else if (lock_req === 1'b0 && lock_grant) begin
                gcnt = 0;
                if (rcnt >= release_delay) lock_grant = 0; else rcnt++;
            end else begin
                gcnt = 0; rcnt = 0;
            end
        end
    end

    // observer
    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (tx_valid === 1'b1 && tx_ready) begin
                got_q.push_back(tx_data); hs_cnt++; last_hs_cyc = cyc;
            end
            if (prev_stall) begin
                stall_cnt++;
                if (tx_valid !== 1'b1 || tx_data !== prev_data) stall_err++;
            end
            prev_stall = (tx_valid === 1'b1) && !tx_ready;
            prev_data  = tx_data;
            if (tx_valid === 1'b1 && !lock_grant) early_tx++;
            if (lock_req === 1'b1) lockreq_cyc++;
            if (prev_lr && lock_req === 1'b0) fall_cyc = cyc;
            prev_lr = (lock_req === 1'b1);
            if (idle === 1'b0 && lock_req === 1'b0 && lock_grant) begin
                rel_cyc++;
                if (imem_addr !== rel_pc) rel_err++;
            end
            if (idle === 1'b0 && imem_addr === 32'h14) at14++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, h, n;
        for (int i = 0; i < 4096; i++) bm[i] = $urandom;
        clr_prog();
        clr_stats();
        reset = 1; running = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_idle", idle, 1);
        chk("rst_pc", imem_addr, 0);
        chk("rst_baddr", bmem_addr, 0);
        chk("rst_lockreq", lock_req, 0);
        chk("rst_txvalid", tx_valid, 0);
        chk("rst_txdata", tx_data, 0);
        chk("rst_err", err, 0);
        @(posedge clock); #1 reset = 0;

        // full block, always ready
        clr_prog();
        im[0] = enc_write(2, 8'hA5, 0);
        ready_mode = 0; grant_delay = 0; release_delay = 0;
        build_exp(2, 8'hA5, 0);
        run_prog("full", 400);
        chk("full_baddr", bmem_addr, 32'h200);
        chk("full_b0", got_q.size() > 0 ? got_q[0] : 8'h00, 8'h41);
        cmp_stream("full");
        chk("full_idle", idle, 1);
        chk("full_pc", imem_addr, 4);
        chk("full_err", err, 0);

        // 3 words, ready toggling
        clr_prog();
        a = $urandom_range(0, 255); h = $urandom_range(0, 255);
        im[0] = enc_write(a, h, 3);
        ready_mode = 1;
        build_exp(a, h, 3);
        run_prog("tog", 400);
        chk("tog_hs", hs_cnt, 17);
        chk("tog_b0", got_q.size() > 0 ? got_q[0] : 8'h00, 8'h0D);
        chk("tog_stall_seen", 32'(stall_cnt > 0), 1);
        chk("tog_stable", stall_err, 0);
        cmp_stream("tog");

        // delayed grant and release
        clr_prog();
        a = $urandom_range(0, 255); h = $urandom_range(0, 255);
        im[0] = enc_write(a, h, 2);
        ready_mode = 0; grant_delay = 10; release_delay = 5; rel_pc = 0;
        build_exp(a, h, 2);
        run_prog("gnt", 400);
        chk("gnt_early_tx", early_tx, 0);
        chk("gnt_lockreq_fall", fall_cyc, last_hs_cyc + 1);
        chk("gnt_release_seen", 32'(rel_cyc > 0), 1);
        chk("gnt_pc_held", rel_err, 0);
        chk("gnt_pc", imem_addr, 4);
        cmp_stream("gnt");
        grant_delay = 0; release_delay = 0;

        // JUMP 5, WAIT 7
        clr_prog();
        im[0] = enc_jump(5);
        im[5] = enc_wait(7);
        run_prog("jw", 100);
        chk("jw_cycles_at_0x14", at14, 1 + 7);
        chk("jw_pc", imem_addr, 32'h18);

        // nwords over the block size
        clr_prog();
        im[0] = enc_write(1, 0, 17);
        run_prog("ovf", 50);
        chk("ovf_err", err, 1);
        chk("ovf_idle", idle, 1);
        chk("ovf_lockreq", lockreq_cyc, 0);

        // running dropped mid-DATA
        clr_prog();
        im[0] = enc_jump(1);
        im[1] = enc_write(3, 8'h5A, 16);
        start_run();
        @(negedge clock);
        chk("drop_err_clr", err, 0);
        wait_hs("drop", 10);
        @(posedge clock); #1 running = 0;
        @(posedge clock); @(negedge clock);
        chk("drop_txvalid", tx_valid, 0);
        chk("drop_lockreq", lock_req, 0);
        chk("drop_idle", idle, 1);
        chk("drop_pc", imem_addr, 4);
        chk("drop_partial", 32'(hs_cnt < 69), 1);

        // lock lost mid-DATA, then restart
        clr_prog();
        im[0] = enc_jump(2);
        im[2] = enc_write(4, 8'h11, 16);
        start_run();
        wait_hs("kill", 8);
        @(posedge clock); #1 grant_kill = 1; lock_grant = 0;
        @(posedge clock); @(negedge clock);
        chk("kill_err", err, 1);
        chk("kill_idle", idle, 1);
        chk("kill_txvalid", tx_valid, 0);
        chk("kill_lockreq", lock_req, 0);
        chk("kill_pc", imem_addr, 8);
        grant_kill = 0;
        clr_prog();
        start_run();
        @(negedge clock);
        chk("restart_pc", imem_addr, 0);
        chk("restart_err", err, 0);
        chk("restart_busy", idle, 0);

        // random writes
        for (int t = 0; t < 4; t++) begin
            clr_prog();
            a = $urandom_range(0, 255); h = $urandom_range(0, 255);
            n = $urandom_range(0, 16);
            im[0] = enc_write(a, h, n);
            ready_mode = 2;
            grant_delay = $urandom_range(0, 5); release_delay = $urandom_range(0, 3);
            build_exp(a, h, n);
            run_prog($sformatf("rnd%0d", t), 600);
            chk($sformatf("rnd%0d_baddr", t), bmem_addr, 32'(a) << 8);
            chk($sformatf("rnd%0d_stable", t), stall_err, 0);
            chk($sformatf("rnd%0d_pc_held", t), rel_err, 0);
            chk($sformatf("rnd%0d_pc", t), imem_addr, 4);
            cmp_stream($sformatf("rnd%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
